// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive sequencer: state encoding,
// legal oversampling ratios and the check-edge position within a bit.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    // The sampler votes at P/2-1..P/2+1, so its result is ready at P/2+2.
    function automatic logic [5:0] chk_edge(input logic [5:0] prescale);
        return (prescale >> 1) + 6'd2;
    endfunction

    function automatic logic presc_legal(input logic [5:0] prescale);
        return (prescale == PRESC_8) || (prescale == PRESC_16) ||
               (prescale == PRESC_32);
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Connection bundle between the receive sequencer and its counter, sampler,
// checkers and deserializer.
interface uart_rx_fsm_if #(
    parameter int unsigned PRESC_W = 6,
    parameter int unsigned BIT_W   = 4
);
    logic               rx_in;
    logic [PRESC_W-1:0] prescale;
    logic               par_en;
    logic [BIT_W-1:0]   bit_cnt;
    logic [PRESC_W-1:0] edge_cnt;
    logic               strt_glitch;
    logic               par_err;
    logic               stp_err;

    logic [PRESC_W-1:0] frm_prescale;
    logic               frm_par_en;
    logic               cnt_en;
    logic               samp_en;
    logic               deser_en;
    logic               strt_chk_en;
    logic               par_chk_en;
    logic               stp_chk_en;
    logic               data_valid;
    logic               par_err_flag;
    logic               frm_err_flag;
    logic               busy;

    modport slave (
        input  rx_in, prescale, par_en, bit_cnt, edge_cnt,
               strt_glitch, par_err, stp_err,
        output frm_prescale, frm_par_en, cnt_en, samp_en, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, par_err_flag, frm_err_flag, busy
    );

    modport master (
        output rx_in, prescale, par_en, bit_cnt, edge_cnt,
               strt_glitch, par_err, stp_err,
        input  frm_prescale, frm_par_en, cnt_en, samp_en, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, par_err_flag, frm_err_flag, busy
    );

endinterface

// File: rtl/uart_rx_chk_point.sv
// Locates the check edge (P/2+2) and the decision edge (P/2+3) inside a bit.
module uart_rx_chk_point
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESC_W = 6
) (
    input  logic [PRESC_W-1:0] prescale_i,
    input  logic [PRESC_W-1:0] edge_cnt_i,
    output logic               at_chk_o,
    output logic               at_dec_o
);

    logic [PRESC_W-1:0] chk;

    assign chk      = chk_edge(prescale_i);
    assign at_chk_o = (edge_cnt_i == chk);
    assign at_dec_o = (edge_cnt_i == chk + 1'b1);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: detects the start bit, freezes the frame
// configuration, strobes the checkers/deserializer and reports the outcome.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PRESC_W = 6,
    parameter int unsigned BIT_W   = 4
) (
    input logic         clk,
    input logic         rst,
    uart_rx_fsm_if.slave bus
);

    localparam logic [BIT_W-1:0] BIT_START = '0;
    localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] BIT_PAR   = BIT_W'(DATA_W + 1);
    localparam logic [BIT_W-1:0] BIT_PSTOP = BIT_W'(DATA_W + 2);

    rx_state_e          state_q;
    logic [PRESC_W-1:0] frm_prescale_q;
    logic               frm_par_en_q;
    logic               data_valid_q;
    logic               par_err_flag_q;
    logic               frm_err_flag_q;

    logic               at_chk;
    logic               at_dec;
    logic [BIT_W-1:0]   stop_bit;

    logic               deser_en_c;
    logic               strt_chk_en_c;
    logic               par_chk_en_c;
    logic               stp_chk_en_c;

    uart_rx_chk_point #(
        .PRESC_W (PRESC_W)
    ) u_chk_point (
        .prescale_i (frm_prescale_q),
        .edge_cnt_i (bus.edge_cnt),
        .at_chk_o   (at_chk),
        .at_dec_o   (at_dec)
    );

    // Stop bit sits one position later when a parity bit is present.
    assign stop_bit = frm_par_en_q ? BIT_PSTOP : BIT_PAR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            frm_prescale_q <= '0;
            frm_par_en_q   <= 1'b0;
            data_valid_q   <= 1'b0;
            par_err_flag_q <= 1'b0;
            frm_err_flag_q <= 1'b0;
        end else begin
            data_valid_q   <= 1'b0;
            par_err_flag_q <= 1'b0;
            frm_err_flag_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.rx_in && presc_legal(bus.prescale)) begin
                        frm_prescale_q <= bus.prescale;
                        frm_par_en_q   <= bus.par_en;
                        state_q        <= START;
                    end
                end
                START: begin
                    if (at_dec && bus.bit_cnt == BIT_START && bus.strt_glitch)
                        state_q <= IDLE;
                    else if (bus.bit_cnt == BIT_FIRST)
                        state_q <= DATA;
                end
                DATA: begin
                    if (bus.bit_cnt == BIT_PAR)
                        state_q <= frm_par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (bus.bit_cnt == BIT_PSTOP)
                        state_q <= STOP;
                end
                STOP: begin
                    // Leaving mid stop bit lets a back-to-back start edge be seen.
                    if (at_dec && bus.bit_cnt == stop_bit) begin
                        if (frm_par_en_q && bus.par_err)
                            par_err_flag_q <= 1'b1;
                        else if (bus.stp_err)
                            frm_err_flag_q <= 1'b1;
                        else
                            data_valid_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        deser_en_c    = 1'b0;
        strt_chk_en_c = 1'b0;
        par_chk_en_c  = 1'b0;
        stp_chk_en_c  = 1'b0;
        case (state_q)
            START:  strt_chk_en_c = at_chk && (bus.bit_cnt == BIT_START);
            DATA:   deser_en_c    = at_chk && (bus.bit_cnt >= BIT_FIRST) &&
                                    (bus.bit_cnt <= BIT_LAST);
            PARITY: par_chk_en_c  = at_chk && (bus.bit_cnt == BIT_PAR);
            STOP:   stp_chk_en_c  = at_chk && (bus.bit_cnt == stop_bit);
            default: ;
        endcase
    end

    assign bus.frm_prescale = frm_prescale_q;
    assign bus.frm_par_en   = frm_par_en_q;
    assign bus.cnt_en       = (state_q != IDLE);
    assign bus.samp_en      = (state_q != IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.deser_en     = deser_en_c;
    assign bus.strt_chk_en  = strt_chk_en_c;
    assign bus.par_chk_en   = par_chk_en_c;
    assign bus.stp_chk_en   = stp_chk_en_c;
    assign bus.data_valid   = data_valid_q;
    assign bus.par_err_flag = par_err_flag_q;
    assign bus.frm_err_flag = frm_err_flag_q;

endmodule
